// File: rtl/obi_sram_bridge_if.sv
// Bus bundle between an OBI core port, the bridge and SRAM port 0.
// Pure wiring; no storage, no latency.
// slave modport is the bridge side; master modport is the core/SRAM side.
interface obi_sram_bridge_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
);
  // OBI request channel
  logic                  obi_req_i;
  logic                  obi_gnt_o;
  logic [31:0]           obi_addr_i;
  logic                  obi_we_i;
  logic [NUM_WMASKS-1:0] obi_be_i;
  logic [DATA_WIDTH-1:0] obi_wdata_i;
  // OBI response channel
  logic                  obi_rvalid_o;
  logic                  obi_rready_i;
  logic [DATA_WIDTH-1:0] obi_rdata_o;
  logic                  obi_err_o;
  // SRAM port 0
  logic                  sram_csb_o;
  logic                  sram_web_o;
  logic [NUM_WMASKS-1:0] sram_wmask_o;
  logic [ADDR_WIDTH-1:0] sram_addr_o;
  logic [DATA_WIDTH-1:0] sram_din_o;
  logic [DATA_WIDTH-1:0] sram_dout_i;

  modport slave (
    input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i, obi_rready_i, sram_dout_i,
    output obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
           sram_csb_o, sram_web_o, sram_wmask_o, sram_addr_o, sram_din_o
  );

  modport master (
    output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i, obi_rready_i, sram_dout_i,
    input  obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
           sram_csb_o, sram_web_o, sram_wmask_o, sram_addr_o, sram_din_o
  );
endinterface

// File: rtl/obi_sram_bridge.sv
// OBI slave -> single-port SRAM bridge with a credit-guarded response FIFO.
// Latency: grant in cycle N -> rvalid in cycle N+2; one access per cycle sustained.
// Backpressure: gnt drops once queued + in-flight responses reach RSP_DEPTH.
// Optional: OBI_SRAM_BRIDGE_ADDR_CHECK_EN flags out-of-range addresses with err=1.
module obi_sram_bridge #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int RSP_DEPTH  = 2
) (
  input logic clk_i,
  input logic rst_ni,
  obi_sram_bridge_if.slave bus
);
  localparam int CW = $clog2(RSP_DEPTH + 2);
  localparam int PW = $clog2(RSP_DEPTH);

  // response FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] r_fifo_dat [RSP_DEPTH];
  logic                  r_fifo_err [RSP_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_cnt;

  // one-deep tracking of the access whose read data arrives next cycle
  logic r_inflight;
  logic r_infl_we;
  logic r_infl_err;

  logic                  w_pop;
  logic                  w_push;
  logic [CW-1:0]         w_credits;
  logic                  w_gnt;
  logic                  w_acc;
  logic                  w_addr_err;
  logic [DATA_WIDTH-1:0] w_push_dat;

`ifdef OBI_SRAM_BRIDGE_ADDR_CHECK_EN
  // any address bit above the SRAM word range marks the request as an error
  logic [31:0] w_addr_hi;
  logic [1:0]  w_unused_addr;
  assign w_addr_hi     = bus.obi_addr_i >> (ADDR_WIDTH + 2);
  assign w_addr_err    = |w_addr_hi;
  assign w_unused_addr = bus.obi_addr_i[1:0];
`else
  // upper bits alias onto the SRAM; byte offset is carried by the byte enables
  logic [31-ADDR_WIDTH:0] w_unused_addr;
  assign w_addr_err    = 1'b0;
  assign w_unused_addr = {bus.obi_addr_i[31:ADDR_WIDTH+2], bus.obi_addr_i[1:0]};
`endif

  // Credits count every response already owed: queued plus the one being read.
  // A slot freed by this cycle's pop can be reused immediately.
  assign w_pop     = bus.obi_rvalid_o & bus.obi_rready_i;
  assign w_credits = r_cnt + CW'(r_inflight) - CW'(w_pop);
  assign w_gnt     = bus.obi_req_i & (w_credits < CW'(RSP_DEPTH)) & rst_ni;
  assign w_acc     = bus.obi_req_i & w_gnt;
  assign w_push    = r_inflight;
  assign w_push_dat = (r_infl_we | r_infl_err) ? '0 : bus.sram_dout_i;

  assign bus.obi_gnt_o    = w_gnt;
  assign bus.sram_csb_o   = ~(w_acc & ~w_addr_err);
  assign bus.sram_web_o   = ~bus.obi_we_i;
  assign bus.sram_wmask_o = bus.obi_be_i;
  assign bus.sram_addr_o  = bus.obi_addr_i[ADDR_WIDTH+1:2];
  assign bus.sram_din_o   = bus.obi_wdata_i;

  // Head of the FIFO drives the response; zeros when empty so reset shows rdata=0.
  assign bus.obi_rvalid_o = (r_cnt != '0);
  assign bus.obi_rdata_o  = bus.obi_rvalid_o ? r_fifo_dat[r_rptr] : '0;
  assign bus.obi_err_o    = bus.obi_rvalid_o ? r_fifo_err[r_rptr] : 1'b0;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Remember the accepted request's type so its data can be captured next cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_inflight <= 1'b0;
      r_infl_we  <= 1'b0;
      r_infl_err <= 1'b0;
    end else begin
      r_inflight <= w_acc;
      r_infl_we  <= bus.obi_we_i;
      r_infl_err <= w_addr_err;
    end
  end

  // Response FIFO: push from the tracking stage, pop on OBI handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        r_fifo_dat[i] <= '0;
        r_fifo_err[i] <= 1'b0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_dat[r_wptr] <= w_push_dat;
        r_fifo_err[r_wptr] <= r_infl_err;
        r_wptr             <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_obi_sram_bridge.sv
// Randomized + directed bench for obi_sram_bridge with an SRAM model,
// a word-level reference memory and an in-order response scoreboard.
module tb_obi_sram_bridge;
  localparam int AW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  obi_sram_bridge_if bus ();
  obi_sram_bridge dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  typedef struct { logic [31:0] d; logic e; } rsp_t;
  rsp_t        exp_q[$];
  logic [31:0] smem   [2**AW];
  logic [31:0] ref_mem[2**AW];
  int n_chk = 0;
  int n_err = 0;
  int n_pops = 0;
  int rr_mode = 1;   // 0: rready low, 1: rready high, 2: random

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // SRAM port-0 model: read data appears the cycle after the access
  always @(posedge clk) begin
    if (!bus.sram_csb_o) begin
      if (!bus.sram_web_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.sram_wmask_o[b]) smem[bus.sram_addr_o][b*8 +: 8] <= bus.sram_din_o[b*8 +: 8];
      end else begin
        bus.sram_dout_i <= smem[bus.sram_addr_o];
      end
    end
  end

  // rready driver
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       bus.obi_rready_i = 1'b0;
      1:       bus.obi_rready_i = 1'b1;
      default: bus.obi_rready_i = 1'($urandom_range(1, 0));
    endcase
  end

  // Reference model: each accepted request yields its expected response
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (bus.obi_req_i && bus.obi_gnt_o) begin
      rsp_t r;
      logic [AW-1:0] idx;
      logic bad;
      idx = bus.obi_addr_i[AW+1:2];
`ifdef OBI_SRAM_BRIDGE_ADDR_CHECK_EN
      bad = (bus.obi_addr_i >= 32'(2**(AW+2)));
`else
      bad = 1'b0;
`endif
      r.e = bad;
      r.d = 32'h0;
      if (!bad) begin
        if (bus.obi_we_i) begin
          for (int b = 0; b < 4; b++)
            if (bus.obi_be_i[b]) ref_mem[idx][b*8 +: 8] = bus.obi_wdata_i[b*8 +: 8];
        end else begin
          r.d = ref_mem[idx];
        end
      end
      exp_q.push_back(r);
    end
  end

  // Monitor: compare each popped response, and check stability under back-pressure
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  logic        hold_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_rvalid", 32'(bus.obi_rvalid_o), 32'd1);
        chk("hold_rdata", bus.obi_rdata_o, hold_d);
        chk("hold_err", 32'(bus.obi_err_o), 32'(hold_e));
      end
      if (bus.obi_rvalid_o && bus.obi_rready_i) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_rsp: got rdata %h with no request outstanding", bus.obi_rdata_o);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          chk("rsp_rdata", bus.obi_rdata_o, e.d);
          chk("rsp_err", 32'(bus.obi_err_o), 32'(e.e));
        end
      end
      hold_v = bus.obi_rvalid_o && !bus.obi_rready_i;
      hold_d = bus.obi_rdata_o;
      hold_e = bus.obi_err_o;
    end
  end

  // Issue one request and hold it until granted (call right after a negedge)
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd);
    int waited;
    waited = 0;
    @(posedge clk); #1;
    bus.obi_req_i = 1'b1; bus.obi_we_i = we; bus.obi_addr_i = addr;
    bus.obi_be_i = be; bus.obi_wdata_i = wd;
    forever begin
      @(negedge clk);
      if (bus.obi_gnt_o) break;
      waited++;
      if (waited > 100) begin
        chk("gnt_timeout", 32'(waited), 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int k;
    @(posedge clk); #1;
    bus.obi_req_i = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((exp_q.size() != 0 || bus.obi_rvalid_o) && k < 200);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int granted;
    logic [31:0] held;
    for (int i = 0; i < 2**AW; i++) begin
      smem[i] = $urandom;
      ref_mem[i] = smem[i];
    end
    bus.sram_dout_i = '0;
    bus.obi_rready_i = 1'b1;
    bus.obi_req_i = 1'b1; bus.obi_we_i = 1'b0; bus.obi_addr_i = 32'h0;
    bus.obi_be_i = 4'hF; bus.obi_wdata_i = 32'h0;

    // Reset state with a pending request
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(bus.obi_gnt_o), 32'd0);
    chk("rst_csb", 32'(bus.sram_csb_o), 32'd1);
    chk("rst_rvalid", 32'(bus.obi_rvalid_o), 32'd0);
    chk("rst_rdata", bus.obi_rdata_o, 32'd0);
    chk("rst_err", 32'(bus.obi_err_o), 32'd0);
    #1 rst_n = 1'b1;
    #1 chk("rel_gnt", 32'(bus.obi_gnt_o), 32'd1);
    bus.obi_req_i = 1'b0;
    @(negedge clk);

    // Write then read 0x10
    @(posedge clk); #1;
    bus.obi_req_i = 1'b1; bus.obi_we_i = 1'b1; bus.obi_addr_i = 32'h10;
    bus.obi_be_i = 4'b0101; bus.obi_wdata_i = 32'hAABBCCDD;
    @(negedge clk);
    chk("wr_gnt", 32'(bus.obi_gnt_o), 32'd1);
    chk("wr_csb", 32'(bus.sram_csb_o), 32'd0);
    chk("wr_web", 32'(bus.sram_web_o), 32'd0);
    chk("wr_wmask", 32'(bus.sram_wmask_o), 32'h5);
    chk("wr_addr", 32'(bus.sram_addr_o), 32'd4);
    chk("wr_din", bus.sram_din_o, 32'hAABBCCDD);
    @(posedge clk); #1;
    bus.obi_we_i = 1'b0;
    @(negedge clk);
    chk("rd_gnt", 32'(bus.obi_gnt_o), 32'd1);
    chk("rd_web", 32'(bus.sram_web_o), 32'd1);
    @(posedge clk); #1;
    bus.obi_req_i = 1'b0;
    @(negedge clk);
    chk("wr_rsp_valid", 32'(bus.obi_rvalid_o), 32'd1);
    chk("wr_rsp_rdata", bus.obi_rdata_o, 32'd0);
    @(negedge clk);
    chk("rd_rsp_valid_n2", 32'(bus.obi_rvalid_o), 32'd1);
    chk("rd_rsp_bytes", bus.obi_rdata_o & 32'h00FF00FF, 32'h00BB00DD);
    @(negedge clk);
    chk("rd_rsp_done", 32'(bus.obi_rvalid_o), 32'd0);

    // Streaming: 8 back-to-back reads
    drain();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.obi_req_i = (i < 8);
      bus.obi_we_i = 1'b0;
      bus.obi_addr_i = 32'h100 + 32'(i * 4);
      @(negedge clk);
      if (i < 8) chk("stream_gnt", 32'(bus.obi_gnt_o), 32'd1);
      chk("stream_rvalid", 32'(bus.obi_rvalid_o), 32'(i >= 2));
    end

    // Back-pressure: only RSP_DEPTH grants with rready low
    drain();
    rr_mode = 0;
    granted = 0;
    held = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus.obi_req_i = 1'b1; bus.obi_we_i = 1'b0;
      bus.obi_addr_i = 32'h200 + 32'(granted * 4);
      @(negedge clk);
      chk("bp_gnt", 32'(bus.obi_gnt_o), 32'(i < 2));
      if (bus.obi_gnt_o) granted++;
      if (i == 2) held = bus.obi_rdata_o;
    end
    chk("bp_granted", 32'(granted), 32'd2);
    chk("bp_rdata_stable", bus.obi_rdata_o, held);
    rr_mode = 1;
    do_req(1'b0, 32'h208, 4'hF, 32'h0);
    do_req(1'b0, 32'h20C, 4'hF, 32'h0);
    drain();

    // Reset with one response queued and one in flight
    rr_mode = 0;
    do_req(1'b0, 32'h300, 4'hF, 32'h0);
    do_req(1'b0, 32'h304, 4'hF, 32'h0);
    @(posedge clk); #1;
    bus.obi_req_i = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk("midrst_rvalid", 32'(bus.obi_rvalid_o), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rr_mode = 1;
    @(negedge clk);
    n_pops = 0;
    do_req(1'b0, 32'h308, 4'hF, 32'h0);
    drain();
    chk("midrst_pops", 32'(n_pops), 32'd1);

    // Upper address bits
    @(posedge clk); #1;
    bus.obi_req_i = 1'b1; bus.obi_we_i = 1'b0; bus.obi_addr_i = 32'h0000_2000;
    @(negedge clk);
    chk("hi_gnt", 32'(bus.obi_gnt_o), 32'd1);
`ifdef OBI_SRAM_BRIDGE_ADDR_CHECK_EN
    chk("hi_csb", 32'(bus.sram_csb_o), 32'd1);
`else
    chk("hi_csb", 32'(bus.sram_csb_o), 32'd0);
    chk("hi_alias_addr", 32'(bus.sram_addr_o), 32'd0);
`endif
    drain();

    // Random traffic with random back-pressure
    rr_mode = 2;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(63, 0)) * 4 + 32'($urandom_range(3, 0));
      if ($urandom_range(7, 0) == 0) a = a | (32'h1 << $urandom_range(31, AW + 2));
      do_req(1'($urandom_range(1, 0)), a, 4'($urandom), $urandom);
      if ($urandom_range(3, 0) == 0) begin
        @(posedge clk); #1;
        bus.obi_req_i = 1'b0;
        @(negedge clk);
      end
    end
    rr_mode = 1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
